// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : int_ctrl
// Description : Programmable interrupt controller feeding CP0 hw_int[5:0].
//               Each source can be synchronised, inverted, latched and gated,
//               and is then routed to one of six lines. Define INTC_SYNC_EN
//               to add a 2-flop input synchronizer on each source.
// Revision    : 1.0  initial release
// ============================================================================
module int_ctrl #(
    parameter int N_SRC = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] src_irq,
    input  logic             cfg_wen,
    input  logic             cfg_ren,
    input  logic [2:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    output logic [5:0]       hw_int
);

    localparam logic [2:0] c_ADDR_RAW   = 3'd0;
    localparam logic [2:0] c_ADDR_EN    = 3'd1;
    localparam logic [2:0] c_ADDR_EDGE  = 3'd2;
    localparam logic [2:0] c_ADDR_POL   = 3'd3;
    localparam logic [2:0] c_ADDR_PEND  = 3'd4;
    localparam logic [2:0] c_ADDR_ROUTE = 3'd5;
    localparam logic [2:0] c_ADDR_HWINT = 3'd6;

    logic [N_SRC-1:0]   w_src;
    logic [N_SRC-1:0]   w_act;
    logic [N_SRC-1:0]   w_pend_nxt;
    logic [5:0]         w_hw_nxt;
    logic [31:0]        w_rdata;
    logic               w_wr_en;
    logic               w_wr_edge;
    logic               w_wr_pol;
    logic               w_wr_pend;
    logic               w_wr_route;
    logic               w_unused;

    logic [N_SRC-1:0]   r_en;
    logic [N_SRC-1:0]   r_edge;
    logic [N_SRC-1:0]   r_pol;
    logic [N_SRC-1:0]   r_pend;
    logic [N_SRC-1:0]   r_prev;
    logic [3*N_SRC-1:0] r_route;

`ifdef INTC_SYNC_EN
    logic [N_SRC-1:0]   r_sync1;
    logic [N_SRC-1:0]   r_sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= src_irq;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src = r_sync2;
`else
    assign w_src = src_irq;
`endif

    assign w_act      = w_src ^ r_pol;
    assign w_wr_en    = cfg_wen && (cfg_addr == c_ADDR_EN);
    assign w_wr_edge  = cfg_wen && (cfg_addr == c_ADDR_EDGE);
    assign w_wr_pol   = cfg_wen && (cfg_addr == c_ADDR_POL);
    assign w_wr_pend  = cfg_wen && (cfg_addr == c_ADDR_PEND);
    assign w_wr_route = cfg_wen && (cfg_addr == c_ADDR_ROUTE);
    assign w_unused   = ^cfg_wdata[31:3*N_SRC];

    // A fresh edge wins over both a W1C and a mode-change clear in the same cycle.
    always_comb begin
        w_pend_nxt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_edge[i] && w_act[i] && !r_prev[i]) begin
                w_pend_nxt[i] = 1'b1;
            end else if (w_wr_edge && (cfg_wdata[i] != r_edge[i])) begin
                w_pend_nxt[i] = 1'b0;
            end else if (r_edge[i]) begin
                w_pend_nxt[i] = r_pend[i] && !(w_wr_pend && cfg_wdata[i]);
            end else begin
                w_pend_nxt[i] = w_act[i];
            end
        end
    end

    // Route codes 6 and 7 never match a line, so those sources stay unrouted.
    for (genvar k = 0; k < 6; k++) begin : g_line
        logic [N_SRC-1:0] w_sel;
        for (genvar i = 0; i < N_SRC; i++) begin : g_src
            assign w_sel[i] = (r_route[3*i +: 3] == 3'(k));
        end
        assign w_hw_nxt[k] = |(r_pend & r_en & w_sel);
    end

    always_comb begin
        w_rdata = '0;
        case (cfg_addr)
            c_ADDR_RAW:   w_rdata[N_SRC-1:0]   = w_act;
            c_ADDR_EN:    w_rdata[N_SRC-1:0]   = r_en;
            c_ADDR_EDGE:  w_rdata[N_SRC-1:0]   = r_edge;
            c_ADDR_POL:   w_rdata[N_SRC-1:0]   = r_pol;
            c_ADDR_PEND:  w_rdata[N_SRC-1:0]   = r_pend;
            c_ADDR_ROUTE: w_rdata[3*N_SRC-1:0] = r_route;
            c_ADDR_HWINT: w_rdata[5:0]         = hw_int;
            default:      w_rdata              = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_en      <= '0;
            r_edge    <= '0;
            r_pol     <= '0;
            r_pend    <= '0;
            r_prev    <= '0;
            r_route   <= '0;
            hw_int    <= '0;
            cfg_rdata <= '0;
        end else begin
            r_prev <= w_act;
            r_pend <= w_pend_nxt;
            hw_int <= w_hw_nxt;
            if (w_wr_en)    r_en    <= cfg_wdata[N_SRC-1:0];
            if (w_wr_edge)  r_edge  <= cfg_wdata[N_SRC-1:0];
            if (w_wr_pol)   r_pol   <= cfg_wdata[N_SRC-1:0];
            if (w_wr_route) r_route <= cfg_wdata[3*N_SRC-1:0];
            if (cfg_ren)    cfg_rdata <= w_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_ctrl
// Description : Scoreboard bench for int_ctrl; stimulus queues expectations,
//               a negedge monitor pops and compares read data and hw_int.
// Revision    : 1.0  initial release
// ============================================================================
module tb_int_ctrl;

    localparam int N = 8;
`ifdef INTC_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic [N-1:0] src_irq   = '0;
    logic         cfg_wen   = 1'b0;
    logic         cfg_ren   = 1'b0;
    logic [2:0]   cfg_addr  = '0;
    logic [31:0]  cfg_wdata = '0;
    logic [31:0]  cfg_rdata;
    logic [5:0]   hw_int;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] rd_q[$];
    string       rd_name[$];
    logic [5:0]  hw_q[$];
    string       hw_name[$];
    logic        rd_done   = 1'b0;
    logic        hw_chk    = 1'b0;
    logic        final_chk = 1'b0;

    int_ctrl #(.N_SRC(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_irq   (src_irq),
        .cfg_wen   (cfg_wen),
        .cfg_ren   (cfg_ren),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .hw_int    (hw_int)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_done <= cfg_ren;

    always @(negedge clk) begin
        logic [31:0] e32;
        logic [5:0]  e6;
        string       nm;
        if (rd_done) begin
            n_vec++;
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: got 0x%08h, none queued", cfg_rdata);
            end else begin
                e32 = rd_q.pop_front();
                nm  = rd_name.pop_front();
                if (cfg_rdata !== e32) begin
                    n_err++;
                    $display("FAIL %s: cfg_rdata=0x%08h expected 0x%08h", nm, cfg_rdata, e32);
                end
            end
        end
        if (hw_chk) begin
            n_vec++;
            if (hw_q.size() == 0) begin
                n_err++;
                $display("FAIL hw_unexpected: got %b, none queued", hw_int);
            end else begin
                e6 = hw_q.pop_front();
                nm = hw_name.pop_front();
                if (hw_int !== e6) begin
                    n_err++;
                    $display("FAIL %s: hw_int=%b expected %b", nm, hw_int, e6);
                end
            end
        end
        if (final_chk) begin
            n_vec++;
            if (rd_q.size() != 0 || hw_q.size() != 0) begin
                n_err++;
                $display("FAIL leftover: %0d reads, %0d hw checks unserved, expected 0",
                         rd_q.size(), hw_q.size());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cfg_wen = 1'b0;
        cfg_ren = 1'b0;
        hw_chk  = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cfg_wen   = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
        cfg_ren  = 1'b1;
        cfg_addr = a;
        rd_q.push_back(e);
        rd_name.push_back(nm);
        tick();
    endtask

    task automatic wrrd(input logic [2:0] a, input logic [31:0] d,
                        input logic [31:0] e, input string nm);
        cfg_wen   = 1'b1;
        cfg_ren   = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        rd_q.push_back(e);
        rd_name.push_back(nm);
        tick();
    endtask

    // Checks hw_int as left by the most recent posedge.
    task automatic chk_hw(input logic [5:0] e, input string nm);
        hw_q.push_back(e);
        hw_name.push_back(nm);
        hw_chk = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset and register defaults, including unmapped index 7
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk_hw(6'b0, "rst_hw");
        for (int i = 0; i < 8; i++) rd(3'(i), 32'h0, $sformatf("rst_rd%0d", i));

        // Level mode on source 0, assert and deassert latency
        wr(3'd1, 32'h01);
        wr(3'd5, 32'h00);
        src_irq[0] = 1'b1;
        repeat (LAT - 1) tick();
        chk_hw(6'b000000, "lvl_early");
        tick();
        chk_hw(6'b000001, "lvl_assert");
        src_irq[0] = 1'b0;
        repeat (LAT - 1) tick();
        chk_hw(6'b000001, "lvl_hold");
        tick();
        chk_hw(6'b000000, "lvl_deassert");
        wr(3'd1, 32'h00);

        // Edge latch on source 2 routed to line 5, then W1C
        wr(3'd2, 32'h04);
        wr(3'd1, 32'h04);
        wr(3'd5, 32'h140);
        src_irq[2] = 1'b1;
        tick();
        src_irq[2] = 1'b0;
        repeat (LAT + 2) tick();
        chk_hw(6'b100000, "edge_latched");
        rd(3'd4, 32'h04, "edge_pend");
        wr(3'd4, 32'h04);
        chk_hw(6'b100000, "w1c_same_cycle");
        tick();
        chk_hw(6'b000000, "w1c_cleared");
        rd(3'd4, 32'h00, "pend_after_w1c");

        // Set beats a same-cycle clear on source 3
        wr(3'd2, 32'h0C);
        src_irq[3] = 1'b1;
        repeat (LAT - 2) tick();
        wr(3'd4, 32'h08);
        rd(3'd4, 32'h08, "set_beats_clear");
        wr(3'd4, 32'h08);
        rd(3'd4, 32'h00, "w1c_no_edge");
        src_irq[3] = 1'b0;

        // Polarity and routing
        wr(3'd2, 32'h00);
        wr(3'd3, 32'h02);
        rd(3'd0, 32'h02, "raw_pol");
        wr(3'd5, 32'h30);
        wr(3'd1, 32'hFF);
        repeat (LAT) tick();
        chk_hw(6'b000000, "unrouted");
        wr(3'd5, 32'h18);
        chk_hw(6'b000000, "route_old");
        tick();
        chk_hw(6'b001000, "route_line3");
        rd(3'd6, 32'h08, "hwint_reg");
        rd(3'd5, 32'h18, "route_reg");

        // Read/write collision, then reset while active
        wr(3'd1, 32'h55);
        wrrd(3'd1, 32'hAA, 32'h55, "rw_old");
        rd(3'd1, 32'hAA, "rw_new");
        chk_hw(6'b001000, "pre_reset_hw");
        rst_n = 1'b0;
        tick();
        chk_hw(6'b000000, "reset_hw");
        rst_n = 1'b1;
        rd(3'd1, 32'h00, "reset_en");
        rd(3'd3, 32'h00, "reset_pol");
        rd(3'd0, 32'h00, "reset_raw");

        tick();
        tick();
        final_chk = 1'b1;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
